display_update_arbiter: RTL

- Shares the display block's three 16-bit indicator inputs (red_leds, green_leds, segments) between two requesters.
  - Requester 0: the CPU GPO path.
  - Requester 1: the key/debug panel.
- Arbitration is round-robin over a valid/ready handshake.
- Granted writes land in shadow registers.
- Shadow registers are copied to the live outputs only at the start of vertical sync, so the VGA overlay never tears mid-frame.
- Sits between the CPU/key logic and the display instance in the clk_video domain.

---
 rtl/display_arb_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 31 +++
 rtl/display_update_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/display_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | display_arb_pkg : shared constants for the display update arbiter          |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
package display_arb_pkg;

  localparam int DEF_DATA_W = 16;

  localparam logic [1:0] SEL_RED   = 2'd0;
  localparam logic [1:0] SEL_GREEN = 2'd1;
  localparam logic [1:0] SEL_SEG   = 2'd2;
  localparam logic [1:0] SEL_ALL   = 2'd3;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ST_IDLE  = 1'b0;
  localparam arb_state_t ST_WRITE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arb2 : two-way round-robin pick with its pointer register               |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  input  logic       granted,
  output logic       winner,
  output logic       any_valid
);

  logic ptr;

  // After a completed grant the other requester gets first refusal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~granted;
    end
  end

  assign any_valid = |valid;
  assign winner    = valid[ptr] ? ptr : ~ptr;

endmodule
`default_nettype wire

// File: rtl/display_update_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | display_update_arbiter : round-robin shared indicator writes, vsync-latched |
// | Optional macro ARB_FORCE_UPDATE_EN adds a forced-update timeout.            |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module display_update_arbiter
  import display_arb_pkg::*;
#(
  parameter int DATA_W           = DEF_DATA_W,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1,
  parameter int WD_CYCLES        = 2000000
) (
  input  logic              clk_video,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [1:0]        req0_sel,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [1:0]        req1_sel,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              vsync,
  output logic [DATA_W-1:0] red_leds,
  output logic [DATA_W-1:0] green_leds,
  output logic [DATA_W-1:0] segments,
  output logic              pending,
  output logic              last_grant
);

  localparam logic VS_ACT = VSYNC_ACTIVE_LOW ? 1'b0 : 1'b1;

  arb_state_t        state;
  logic              win;
  logic              pick;
  logic              any_valid;
  logic              wr_en;
  logic [1:0]        wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] shadow_red, shadow_green, shadow_seg;
  logic              vsync_q;
  logic              vs_edge;
  logic              wd_fire;
  logic              copy;

  assign req0_ready = (state == ST_WRITE) && !win && req0_valid;
  assign req1_ready = (state == ST_WRITE) &&  win && req1_valid;
  assign wr_en      = req0_ready | req1_ready;
  assign wr_sel     = win ? req1_sel  : req0_sel;
  assign wr_data    = win ? req1_data : req0_data;

  rr_arb2 u_rr (
    .clk       (clk_video),
    .rst_n     (reset_n),
    .valid     ({req1_valid, req0_valid}),
    .advance   (wr_en),
    .granted   (win),
    .winner    (pick),
    .any_valid (any_valid)
  );

  assign vs_edge = (vsync == VS_ACT) && (vsync_q != VS_ACT);
  // Live registers sample the shadows before any same-cycle write lands.
  assign copy    = pending && (vs_edge || wd_fire);

`ifdef ARB_FORCE_UPDATE_EN
  localparam int WD_W = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
  logic [WD_W-1:0] wd_cnt;

  assign wd_fire = pending && (wd_cnt == WD_W'(WD_CYCLES - 1));

  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (!pending || vs_edge || wd_fire) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  // Timeout absent: only a vsync edge ever publishes the shadows.
  assign wd_fire = (WD_CYCLES < 0);
`endif

  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      win   <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (any_valid) begin
        state <= ST_WRITE;
        win   <= pick;
      end
    end else begin
      state <= ST_IDLE;
    end
  end

  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      shadow_red   <= '0;
      shadow_green <= '0;
      shadow_seg   <= '0;
      red_leds     <= '0;
      green_leds   <= '0;
      segments     <= '0;
      pending      <= 1'b0;
      last_grant   <= 1'b0;
      vsync_q      <= ~VS_ACT;
    end else begin
      vsync_q <= vsync;
      if (copy) begin
        red_leds   <= shadow_red;
        green_leds <= shadow_green;
        segments   <= shadow_seg;
      end
      if (wr_en) begin
        if (wr_sel == SEL_RED   || wr_sel == SEL_ALL) shadow_red   <= wr_data;
        if (wr_sel == SEL_GREEN || wr_sel == SEL_ALL) shadow_green <= wr_data;
        if (wr_sel == SEL_SEG   || wr_sel == SEL_ALL) shadow_seg   <= wr_data;
        pending    <= 1'b1;
        last_grant <= win;
      end else if (copy) begin
        pending <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
